// File: rtl/pri_enc8_irq.sv
// 8-line rising-edge interrupt priority encoder with pending register,
// per-line mask and a present/ack/gap handshake (bit 0 highest priority).
module pri_enc8_irq (
  input  logic       sys_clk,
  input  logic       resetl,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic       irq_n,
  output logic [7:0] pending
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_e;

  state_e     state_q, state_d;
  logic [7:0] req_q;
  logic [7:0] pend_q, pend_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       irq_n_q;

  logic [7:0] rise, elig, clr;
  logic [2:0] sel;

  assign rise = req & ~req_q;
  assign elig = pend_q & mask;

  // Scan from the top down so the lowest set index is the one left in sel.
  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (elig[i]) sel = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    clr     = 8'h00;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          code_d  = sel;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          clr     = 8'h01 << code_q;
          valid_d = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    // A new edge wins over the ack clearing the same bit.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      state_q <= IDLE;
      req_q   <= req;
      pend_q  <= 8'h00;
      code_q  <= 3'd0;
      valid_q <= 1'b0;
      irq_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req;
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      irq_n_q <= ~valid_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign irq_n   = irq_n_q;
  assign pending = pend_q;

endmodule
